// File: rtl/mem_arbiter_rr.sv
// N-port cacheline memory arbiter.
// Multiplexes NUM_PORTS cache-side line requests onto one downstream line port.
// Supports round-robin arbitration or fixed priority with starvation promotion.
// The grant is registered, and the downstream signals are combinational from it.
module mem_arbiter_rr #(
  parameter int NUM_PORTS    = 2,
  parameter int LINE_W       = 256,
  parameter int ADDR_W       = 32,
  parameter int PRIO_MODE    = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_PORTS-1:0]           req_read,
  input  logic [NUM_PORTS-1:0]           req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]    req_address,
  input  logic [NUM_PORTS*LINE_W-1:0]    req_wdata,
  output logic [LINE_W-1:0]              req_rdata,
  output logic [NUM_PORTS-1:0]           req_resp,
  output logic                           mem_read,
  output logic                           mem_write,
  output logic [ADDR_W-1:0]              mem_address,
  output logic [LINE_W-1:0]              mem_wdata,
  input  logic [LINE_W-1:0]              mem_rdata,
  input  logic                           mem_resp,
  output logic [$clog2(NUM_PORTS)-1:0]   grant_id,
  output logic                           busy
);

  localparam int ID_W  = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t               state;
  logic [ID_W-1:0]      ptr;
  logic [CNT_W-1:0]     starve_cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0] active;
  logic                 any_active;
  logic [ID_W-1:0]      winner;

  assign active     = req_read | req_write;
  assign any_active = |active;
  assign busy       = (state == ST_BUSY);

  // Round-robin pointer advance: the port after k, wrapping at NUM_PORTS.
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] k);
    if (int'(k) == NUM_PORTS - 1) return '0;
    else                          return k + ID_W'(1);
  endfunction

  // Select the winning port for the next IDLE arbitration.
  always_comb begin
    logic            found;
    logic [ID_W-1:0] idx;
    int              j;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    j      = 0;
    if (PRIO_MODE == 0) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        j = int'(ptr) + i;
        if (j >= NUM_PORTS) j = j - NUM_PORTS;
        idx = ID_W'(j);
        if (!found && active[idx]) begin
          found  = 1'b1;
          winner = idx;
        end
      end
    end else begin
      // Starved ports take precedence; lowest index among them wins.
      for (int i = 0; i < NUM_PORTS; i++) begin
        idx = ID_W'(i);
        if (!found && active[idx] && starve_cnt[idx] == CNT_W'(STARVE_LIMIT)) begin
          found  = 1'b1;
          winner = idx;
        end
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        idx = ID_W'(i);
        if (!found && active[idx]) begin
          found  = 1'b1;
          winner = idx;
        end
      end
    end
  end

  // Route the granted port downstream and return the completion to it.
  always_comb begin
    logic [ID_W-1:0] idx;
    idx         = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    req_resp    = '0;
    req_rdata   = '0;
    if (state == ST_BUSY) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        idx = ID_W'(i);
        if (grant_id == idx) begin
          // A write wins if both strobes are (illegally) raised together.
          mem_write   = req_write[idx];
          mem_read    = req_read[idx] & ~req_write[idx];
          mem_address = req_address[i*ADDR_W +: ADDR_W];
          mem_wdata   = req_wdata[i*LINE_W +: LINE_W];
        end
      end
      if (mem_resp) begin
        req_resp[grant_id] = 1'b1;
        req_rdata          = mem_rdata;
      end
    end
  end

  // Arbitration FSM: grant in IDLE, release on downstream completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      grant_id <= '0;
      ptr      <= '0;
      for (int i = 0; i < NUM_PORTS; i++) starve_cnt[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_active) begin
            state    <= ST_BUSY;
            grant_id <= winner;
            if (PRIO_MODE == 0) begin
              ptr <= next_ptr(winner);
            end else begin
              for (int i = 0; i < NUM_PORTS; i++) begin
                if (ID_W'(i) == winner)
                  starve_cnt[i] <= '0;
                else if (active[ID_W'(i)] && starve_cnt[i] != CNT_W'(STARVE_LIMIT))
                  starve_cnt[i] <= starve_cnt[i] + CNT_W'(1);
              end
            end
          end
        end
        ST_BUSY: begin
          // The grant returns to 0 so that grant_id reads 0 whenever idle.
          if (mem_resp) begin
            state    <= ST_IDLE;
            grant_id <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The granted port must hold its request until the downstream completes.
  a_req_held: assert property (@(posedge clk) disable iff (!reset_n)
    (state == ST_BUSY && !mem_resp) |-> (req_read[grant_id] || req_write[grant_id]));

  // A port may not raise read and write together.
  a_no_rw: assert property (@(posedge clk) disable iff (!reset_n)
    !(|(req_read & req_write)));

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr.
// Instance a is the default two-port round-robin arbiter.
// Instance b is a four-port round-robin arbiter.
// Instance c is a three-port fixed-priority arbiter with a starvation limit of 2.
module tb_mem_arbiter_rr;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance a
  logic [1:0]   req_read_a, req_write_a, req_resp_a;
  logic [63:0]  req_address_a;
  logic [511:0] req_wdata_a;
  logic [255:0] req_rdata_a, mem_wdata_a, mem_rdata_a;
  logic         mem_read_a, mem_write_a, mem_resp_a, busy_a;
  logic [31:0]  mem_address_a;
  logic [0:0]   grant_id_a;

  // Instance b
  logic [3:0]   req_read_b, req_write_b, req_resp_b;
  logic [63:0]  req_address_b;
  logic [127:0] req_wdata_b;
  logic [31:0]  req_rdata_b, mem_wdata_b, mem_rdata_b;
  logic         mem_read_b, mem_write_b, mem_resp_b, busy_b;
  logic [15:0]  mem_address_b;
  logic [1:0]   grant_id_b;

  // Instance c
  logic [2:0]   req_read_c, req_write_c, req_resp_c;
  logic [47:0]  req_address_c;
  logic [95:0]  req_wdata_c;
  logic [31:0]  req_rdata_c, mem_wdata_c, mem_rdata_c;
  logic         mem_read_c, mem_write_c, mem_resp_c, busy_c;
  logic [15:0]  mem_address_c;
  logic [1:0]   grant_id_c;

  mem_arbiter_rr u_a (
    .clk(clk), .reset_n(reset_n),
    .req_read(req_read_a), .req_write(req_write_a),
    .req_address(req_address_a), .req_wdata(req_wdata_a),
    .req_rdata(req_rdata_a), .req_resp(req_resp_a),
    .mem_read(mem_read_a), .mem_write(mem_write_a),
    .mem_address(mem_address_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a), .mem_resp(mem_resp_a),
    .grant_id(grant_id_a), .busy(busy_a)
  );

  mem_arbiter_rr #(.NUM_PORTS(4), .LINE_W(32), .ADDR_W(16), .PRIO_MODE(0)) u_b (
    .clk(clk), .reset_n(reset_n),
    .req_read(req_read_b), .req_write(req_write_b),
    .req_address(req_address_b), .req_wdata(req_wdata_b),
    .req_rdata(req_rdata_b), .req_resp(req_resp_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b),
    .mem_address(mem_address_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .mem_resp(mem_resp_b),
    .grant_id(grant_id_b), .busy(busy_b)
  );

  mem_arbiter_rr #(.NUM_PORTS(3), .LINE_W(32), .ADDR_W(16), .PRIO_MODE(1),
                   .STARVE_LIMIT(2)) u_c (
    .clk(clk), .reset_n(reset_n),
    .req_read(req_read_c), .req_write(req_write_c),
    .req_address(req_address_c), .req_wdata(req_wdata_c),
    .req_rdata(req_rdata_c), .req_resp(req_resp_c),
    .mem_read(mem_read_c), .mem_write(mem_write_c),
    .mem_address(mem_address_c), .mem_wdata(mem_wdata_c),
    .mem_rdata(mem_rdata_c), .mem_resp(mem_resp_c),
    .grant_id(grant_id_c), .busy(busy_c)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] gb [5];
  logic [1:0] gc [6];
  int         ib [5];
  int         ic [6];
  logic [1:0] exp_b [5];
  logic [1:0] exp_c [6];

  initial begin
    int nb, nc, idle_b, idle_c, bcnt_b, bcnt_c, cyc;
    logic pbusy_b, pbusy_c;

    exp_b = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_c = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd2};
    for (int i = 0; i < 5; i++) begin gb[i] = 'x; ib[i] = -1; end
    for (int i = 0; i < 6; i++) begin gc[i] = 'x; ic[i] = -1; end

    req_read_a = '0; req_write_a = '0; req_address_a = '0; req_wdata_a = '0;
    mem_rdata_a = '0; mem_resp_a = 1'b0;
    req_read_b = '0; req_write_b = '0; req_address_b = '0; req_wdata_b = '0;
    mem_rdata_b = '0; mem_resp_b = 1'b0;
    req_read_c = '0; req_write_c = '0; req_address_c = '0; req_wdata_c = '0;
    mem_rdata_c = '0; mem_resp_c = 1'b0;

    // Reset state
    tick();
    chk("rst_busy", busy_a, 0);
    chk("rst_grant", grant_id_a, 0);
    chk("rst_mem_read", mem_read_a, 0);
    tick();
    reset_n = 1'b1;

    // Asynchronous reset in the middle of a transaction with mem_resp pending
    tick();
    req_read_a = 2'b10;
    req_address_a[63:32] = 32'h0000_2000;
    tick();
    chk("t1_busy", busy_a, 1);
    mem_resp_a  = 1'b1;
    mem_rdata_a = {32{8'h5A}};
    #2 reset_n = 1'b0;
    #1;
    chk("t1_rst_mem_read", mem_read_a, 0);
    chk("t1_rst_resp", req_resp_a, 0);
    chk("t1_rst_busy", busy_a, 0);
    chk("t1_rst_grant", grant_id_a, 0);
    chk("t1_rst_addr", mem_address_a, 0);
    chk("t1_rst_rdata", req_rdata_a, 0);
    mem_resp_a = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("t1_regrant_id", grant_id_a, 1);
    chk("t1_regrant_read", mem_read_a, 1);
    chk("t1_regrant_addr", mem_address_a, 32'h0000_2000);
    mem_resp_a = 1'b1;
    #1;
    chk("t1_resp", req_resp_a, 2'b10);
    tick();
    mem_resp_a = 1'b0;
    req_read_a = '0;
    #1;
    chk("t1_idle", busy_a, 0);

    // Single read from port 1
    tick();
    req_read_a = 2'b10;
    req_address_a[63:32] = 32'h0000_1240;
    #1;
    chk("t2_t0_busy", busy_a, 0);
    chk("t2_t0_read", mem_read_a, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t2_read", mem_read_a, 1);
      chk("t2_addr", mem_address_a, 32'h0000_1240);
      chk("t2_noresp", req_resp_a, 0);
    end
    tick();
    mem_resp_a  = 1'b1;
    mem_rdata_a = {32{8'hA5}};
    #1;
    chk("t2_t5_read", mem_read_a, 1);
    chk("t2_t5_resp", req_resp_a, 2'b10);
    chk("t2_t5_rdata", req_rdata_a, {32{8'hA5}});
    tick();
    mem_resp_a = 1'b0;
    req_read_a = '0;
    #1;
    chk("t2_t6_busy", busy_a, 0);
    chk("t2_t6_resp", req_resp_a, 0);

    // Write from port 0
    tick();
    req_write_a = 2'b01;
    req_address_a[31:0] = 32'h0000_0080;
    req_wdata_a[255:0]  = {16{16'h1234}};
    tick();
    chk("t5_write", mem_write_a, 1);
    chk("t5_read", mem_read_a, 0);
    chk("t5_addr", mem_address_a, 32'h0000_0080);
    chk("t5_wdata", mem_wdata_a, {16{16'h1234}});
    chk("t5_grant", grant_id_a, 0);
    mem_resp_a = 1'b1;
    #1;
    chk("t5_resp", req_resp_a, 2'b01);
    tick();
    mem_resp_a  = 1'b0;
    req_write_a = '0;
    #1;
    chk("t5_idle", busy_a, 0);

    // Stray mem_resp while idle
    tick();
    mem_resp_a = 1'b1;
    #1;
    chk("t6_resp", req_resp_a, 0);
    chk("t6_write", mem_write_a, 0);
    tick();
    chk("t6_busy", busy_a, 0);
    chk("t6_grant", grant_id_a, 0);
    mem_resp_a = 1'b0;

    // Round-robin on b and fixed priority on c, both with a 2-cycle downstream
    nb = 0; nc = 0; idle_b = 0; idle_c = 0; bcnt_b = 0; bcnt_c = 0;
    pbusy_b = 1'b0; pbusy_c = 1'b0;
    req_read_b = 4'hF;
    req_read_c = 3'b101;
    cyc = 0;
    while (cyc < 80 && (nb < 5 || nc < 6)) begin
      tick();
      cyc++;
      if (busy_b && !pbusy_b && nb < 5) begin
        gb[nb] = grant_id_b; ib[nb] = idle_b; nb++;
      end
      if (busy_b) begin
        bcnt_b = pbusy_b ? bcnt_b + 1 : 0;
        idle_b = 0;
      end else begin
        idle_b++;
      end
      mem_resp_b = busy_b && (bcnt_b == 1);
      pbusy_b = busy_b;

      if (busy_c && !pbusy_c && nc < 6) begin
        gc[nc] = grant_id_c; ic[nc] = idle_c; nc++;
      end
      if (busy_c) begin
        bcnt_c = pbusy_c ? bcnt_c + 1 : 0;
        idle_c = 0;
      end else begin
        idle_c++;
      end
      mem_resp_c = busy_c && (bcnt_c == 1);
      pbusy_c = busy_c;
    end

    chk("t3_grant_count", nb, 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_grant%0d", i), gb[i], exp_b[i]);
      if (i > 0) chk($sformatf("t3_gap%0d", i), ib[i], 1);
    end
    chk("t4_grant_count", nc, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t4_grant%0d", i), gc[i], exp_c[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
